// File: rtl/simon_pkg.sv
// Shared types for the Simon game datapath: colour index, scheduler state
// encoding and the colour-to-LED one-hot mapping.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPEND   = 3'd1,
    S_PLAY_ON  = 3'd2,
    S_PLAY_GAP = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_LOST     = 3'd5,
    S_WON      = 3'd6
  } sched_state_t;

  function automatic logic [3:0] color_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: one synchronous write port, two asynchronous read
// ports (playback and input checking). No reset on the array.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  color_t        wdata,
  input  logic [AW-1:0] play_addr,
  output color_t        play_data,
  input  logic [AW-1:0] in_addr,
  output color_t        in_data
);

  color_t mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign play_data = mem[play_addr];
  assign in_data   = mem[in_addr];

endmodule

// File: rtl/simon_seq_sched.sv
// Simon sequence scheduler: grows the colour sequence, plays it back with
// fixed on/gap timing, then checks the player's presses against it.
module simon_seq_sched
  import simon_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          start_round,
  input  logic [1:0]    rand_color,
  input  logic [3:0]    btn_press,
  output logic [3:0]    play_led,
  output logic          sound,
  output logic          end_of_sequence,
  output logic          correct_input,
  output logic          wrong_input,
  output logic          round_done,
  output logic          game_won,
  output logic [LW-1:0] seq_len
);

  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  sched_state_t  state_q, state_d;
  logic [LW-1:0] seq_len_q, seq_len_d;
  logic [LW-1:0] play_idx_q, play_idx_d;
  logic [LW-1:0] in_idx_q, in_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  color_t        color_q, color_d;
  logic [3:0]    play_led_q, play_led_d;
  logic          sound_q, sound_d;
  logic          eos_q, eos_d;
  logic          correct_q, correct_d;
  logic          wrong_q, wrong_d;
  logic          done_q, done_d;
  logic          won_q, won_d;
  logic          we;
  color_t        play_color, in_color, led_color;

  simon_seq_mem #(.MAX_LEN(MAX_LEN), .AW(AW)) u_mem (
    .clk       (clk),
    .we        (we),
    .waddr     (seq_len_q[AW-1:0]),
    .wdata     (color_q),
    .play_addr (play_idx_d[AW-1:0]),
    .play_data (play_color),
    .in_addr   (in_idx_q[AW-1:0]),
    .in_data   (in_color)
  );

  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    play_idx_d = play_idx_q;
    in_idx_d   = in_idx_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    color_d    = color_q;
    eos_d      = 1'b0;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    done_d     = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_round && (seq_len_q < LW'(MAX_LEN))) begin
          state_d = S_APPEND;
          color_d = rand_color;
        end
      end
      S_APPEND: begin
        we         = 1'b1;
        seq_len_d  = seq_len_q + LW'(1);
        play_idx_d = '0;
        cnt_d      = CW'(ON_CYCLES - 1);
        state_d    = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = S_PLAY_GAP;
        end
      end
      S_PLAY_GAP: begin
        if (cnt_q == '0) begin
          if (play_idx_q == seq_len_q - LW'(1)) begin
            eos_d    = 1'b1;
            in_idx_d = '0;
            state_d  = S_WAIT_IN;
          end else begin
            play_idx_d = play_idx_q + LW'(1);
            cnt_d      = CW'(ON_CYCLES - 1);
            state_d    = S_PLAY_ON;
          end
        end
      end
      S_WAIT_IN: begin
        // Exact one-hot equality, so multi-bit presses always mismatch
        if (btn_press != 4'b0000) begin
          if (btn_press == color_onehot(in_color)) begin
            correct_d = 1'b1;
            if (in_idx_q == seq_len_q - LW'(1)) begin
              done_d  = 1'b1;
              state_d = (seq_len_q == LW'(MAX_LEN)) ? S_WON : S_IDLE;
            end else begin
              in_idx_d = in_idx_q + LW'(1);
            end
          end else begin
            wrong_d = 1'b1;
            state_d = S_LOST;
          end
        end
      end
      default: ;
    endcase
    if (new_game) begin
      state_d    = S_IDLE;
      seq_len_d  = '0;
      play_idx_d = '0;
      in_idx_d   = '0;
      cnt_d      = '0;
      eos_d      = 1'b0;
      correct_d  = 1'b0;
      wrong_d    = 1'b0;
      done_d     = 1'b0;
      we         = 1'b0;
    end
  end

  // Entry 0 is written during APPEND while it is already needed for the LED
  always_comb begin
    led_color  = (state_q == S_APPEND && play_idx_d == seq_len_q) ? color_q : play_color;
    play_led_d = (state_d == S_PLAY_ON) ? color_onehot(led_color) : 4'b0000;
    sound_d    = (play_led_d != 4'b0000);
    won_d      = (state_d == S_WON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seq_len_q  <= '0;
      play_idx_q <= '0;
      in_idx_q   <= '0;
      cnt_q      <= '0;
      color_q    <= '0;
      play_led_q <= '0;
      sound_q    <= 1'b0;
      eos_q      <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      done_q     <= 1'b0;
      won_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_len_q  <= seq_len_d;
      play_idx_q <= play_idx_d;
      in_idx_q   <= in_idx_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      play_led_q <= play_led_d;
      sound_q    <= sound_d;
      eos_q      <= eos_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      done_q     <= done_d;
      won_q      <= won_d;
    end
  end

  assign play_led        = play_led_q;
  assign sound           = sound_q;
  assign end_of_sequence = eos_q;
  assign correct_input   = correct_q;
  assign wrong_input     = wrong_q;
  assign round_done      = done_q;
  assign game_won        = won_q;
  assign seq_len         = seq_len_q;

endmodule

// File: tb/tb_simon_seq_sched.sv
// Bench for simon_seq_sched: directed game scenarios plus random games, checked
// against a queue-based model of the game rules.
module tb_simon_seq_sched;

  localparam int ML = 4;
  localparam int ON = 4;
  localparam int GP = 2;
  localparam int M_IDLE = 0, M_WAIT = 1, M_LOST = 2, M_WON = 3;

  logic       clk = 1'b0;
  logic       rst, new_game, start_round;
  logic [1:0] rand_color;
  logic [3:0] btn_press;
  logic [3:0] play_led;
  logic       sound, end_of_sequence, correct_input, wrong_input, round_done, game_won;
  logic [2:0] seq_len;

  int checks = 0;
  int errors = 0;
  int model_q[$];
  int mode = M_IDLE;
  int idx  = 0;

  simon_seq_sched #(.MAX_LEN(ML), .ON_CYCLES(ON), .GAP_CYCLES(GP)) dut (
    .clk             (clk),
    .rst             (rst),
    .new_game        (new_game),
    .start_round     (start_round),
    .rand_color      (rand_color),
    .btn_press       (btn_press),
    .play_led        (play_led),
    .sound           (sound),
    .end_of_sequence (end_of_sequence),
    .correct_input   (correct_input),
    .wrong_input     (wrong_input),
    .round_done      (round_done),
    .game_won        (game_won),
    .seq_len         (seq_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " correct"}, correct_input, 0);
    chk({tag, " wrong"}, wrong_input, 0);
    chk({tag, " round_done"}, round_done, 0);
  endtask

  task automatic do_new_game(input logic [3:0] b);
    new_game = 1'b1;
    btn_press = b;
    step();
    new_game = 1'b0;
    btn_press = 4'b0;
    model_q.delete();
    mode = M_IDLE;
    idx = 0;
    chk_quiet("new_game");
    chk("new_game seq_len", seq_len, 0);
    chk("new_game won", game_won, 0);
    chk("new_game led", play_led, 0);
  endtask

  // Drives start_round and follows the whole playback that the rules predict
  task automatic start_round_chk(input logic [1:0] col);
    bit acc;
    int n, total, k, j;
    logic [3:0] exp_led;
    acc = (mode == M_IDLE) && (model_q.size() < ML);
    if (acc) model_q.push_back(int'(col));
    n = model_q.size();
    total = acc ? 2 + n * (ON + GP) : 8;
    start_round = 1'b1;
    rand_color = col;
    for (int c = 1; c <= total; c++) begin
      step();
      start_round = 1'b0;
      rand_color = 2'($urandom_range(0, 3));
      btn_press = ((!acc || c < total) && (c % 3 == 0)) ? 4'($urandom_range(1, 15)) : 4'b0;
      exp_led = 4'b0;
      if (acc && c >= 2 && c < total) begin
        k = (c - 2) / (ON + GP);
        j = (c - 2) % (ON + GP);
        if (j < ON) exp_led = 4'b0001 << model_q[k];
      end
      chk("play_led", play_led, exp_led);
      chk("sound", sound, exp_led != 4'b0);
      chk("eos", end_of_sequence, acc && c == total);
      chk_quiet("playback");
      chk("play seq_len", seq_len, (acc && c == 1) ? n - 1 : n);
      chk("play won", game_won, mode == M_WON);
    end
    btn_press = 4'b0;
    if (acc) begin
      mode = M_WAIT;
      idx = 0;
    end
  endtask

  task automatic do_press(input logic [3:0] b);
    logic ec, ew, er;
    ec = 1'b0; ew = 1'b0; er = 1'b0;
    if (mode == M_WAIT && b != 4'b0) begin
      if (b == (4'b0001 << model_q[idx])) begin
        ec = 1'b1;
        if (idx == model_q.size() - 1) begin
          er = 1'b1;
          mode = (model_q.size() == ML) ? M_WON : M_IDLE;
        end else idx++;
      end else begin
        ew = 1'b1;
        mode = M_LOST;
      end
    end
    btn_press = b;
    step();
    btn_press = 4'b0;
    chk("press correct", correct_input, ec);
    chk("press wrong", wrong_input, ew);
    chk("press round_done", round_done, er);
    chk("press won", game_won, mode == M_WON);
    chk("press seq_len", seq_len, model_q.size());
    chk("press led", play_led, 0);
  endtask

  function automatic logic [3:0] good_btn();
    return 4'b0001 << model_q[idx];
  endfunction

  function automatic logic [3:0] bad_btn();
    logic [3:0] b;
    b = 4'($urandom_range(1, 15));
    if (b == good_btn()) b = good_btn() ^ 4'b1000 ^ 4'b0001;
    return b;
  endfunction

  initial begin
    rst = 1'b1; new_game = 1'b0; start_round = 1'b0;
    rand_color = 2'd0; btn_press = 4'b0;
    step(); step(); step();
    chk("reset led", play_led, 0);
    chk("reset sound", sound, 0);
    chk("reset eos", end_of_sequence, 0);
    chk_quiet("reset");
    chk("reset won", game_won, 0);
    chk("reset seq_len", seq_len, 0);
    rst = 1'b0;
    step();

    // Sequence {2,0,...} grown to full length, all correct
    do_new_game(4'b0);
    start_round_chk(2'd2);
    do_press(4'b0100);
    start_round_chk(2'd0);
    do_press(4'b0100);
    do_press(4'b0001);
    repeat (2) begin
      start_round_chk(2'($urandom_range(0, 3)));
      while (mode == M_WAIT) do_press(good_btn());
    end
    chk("won after 4 rounds", game_won, 1);
    start_round_chk(2'd1);
    do_press(4'b0001);

    // Wrong press, then everything ignored until new_game
    do_new_game(4'b0);
    start_round_chk(2'd1);
    do_press(4'b0100);
    start_round_chk(2'd3);
    do_press(4'b0010);
    do_press(4'b1000);

    // Multi-bit press is a mismatch
    do_new_game(4'b0);
    start_round_chk(2'd2);
    do_press(4'b0110);

    // new_game wins over a same-cycle press, state returns to IDLE
    do_new_game(4'b0);
    start_round_chk(2'd3);
    do_new_game(4'b1000);
    step();
    chk_quiet("after new_game");
    start_round_chk(2'd0);
    do_press(4'b0001);

    // Reset in the middle of PLAY_ON
    do_new_game(4'b0);
    start_round = 1'b1; rand_color = 2'd1;
    step(); start_round = 1'b0;
    step(); step();
    chk("pre-rst led", play_led, 4'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete(); mode = M_IDLE; idx = 0;
    chk("rst led", play_led, 0);
    chk("rst sound", sound, 0);
    chk("rst seq_len", seq_len, 0);

    // Random games with occasional mistakes
    repeat (6) begin
      do_new_game(4'b0);
      for (int r = 0; r < ML && mode == M_IDLE; r++) begin
        start_round_chk(2'($urandom_range(0, 3)));
        while (mode == M_WAIT) begin
          if ($urandom_range(0, 7) == 0) do_press(bad_btn());
          else do_press(good_btn());
        end
      end
      start_round_chk(2'($urandom_range(0, 3)));
      if (mode == M_WAIT) while (mode == M_WAIT) do_press(good_btn());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
